// File: rtl/divu_xnyn.sv
// Sequential restoring unsigned divider: quotient and remainder of x / y, one quotient bit per clock.
// Optional macro DIVU_DIV0_EN adds a div0 flag and a 1-cycle fast path for a zero divisor.
module divu_xnyn #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             rdy,
    output logic             busy,
    output logic             valid
`ifdef DIVU_DIV0_EN
    ,
    output logic             div0
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH:0]   rem_reg;
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] y_reg;
    logic [CW-1:0]    cnt_reg;

    logic [WIDTH+1:0] shifted;
    logic             ge;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] dvd_next;

    // One restoring step: shift {rem, dividend} left, trial-subtract the divisor.
    always_comb begin
        shifted  = {rem_reg, dvd_reg[WIDTH-1]};
        ge       = (shifted >= {2'b00, y_reg});
        rem_next = ge ? (WIDTH+1)'(shifted - {2'b00, y_reg}) : shifted[WIDTH:0];
        dvd_next = {dvd_reg[WIDTH-2:0], ge};
    end

    assign rdy = ~busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            rem_reg   <= '0;
            dvd_reg   <= '0;
            y_reg     <= '0;
            cnt_reg   <= '0;
            q         <= '0;
            r         <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
`ifdef DIVU_DIV0_EN
            div0      <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        y_reg   <= y;
                        dvd_reg <= x;
                        rem_reg <= '0;
                        cnt_reg <= CW'(WIDTH);
                        valid   <= 1'b0;
`ifdef DIVU_DIV0_EN
                        div0    <= (y == '0);
                        if (y == '0) begin
                            // Zero divisor short-cuts to the result the iteration would produce.
                            state_reg <= DONE;
                            valid     <= 1'b1;
                            busy      <= 1'b0;
                            q         <= '1;
                            r         <= x;
                        end else begin
                            state_reg <= BUSY;
                            busy      <= 1'b1;
                        end
`else
                        state_reg <= BUSY;
                        busy      <= 1'b1;
`endif
                    end
                end
                BUSY: begin
                    rem_reg <= rem_next;
                    dvd_reg <= dvd_next;
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == CW'(1)) begin
                        state_reg <= DONE;
                        busy      <= 1'b0;
                        valid     <= 1'b1;
                        q         <= dvd_next;
                        r         <= rem_next[WIDTH-1:0];
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    valid     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divu_xnyn.sv
// Self-checking bench for divu_xnyn (WIDTH=4) against a plain-arithmetic division model.
module tb_divu_xnyn;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         rdy;
    logic         busy;
    logic         valid;
`ifdef DIVU_DIV0_EN
    logic         div0;
`endif

    int passed = 0;
    int total  = 0;

    divu_xnyn #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .q     (q),
        .r     (r),
        .rdy   (rdy),
        .busy  (busy),
        .valid (valid)
`ifdef DIVU_DIV0_EN
        ,
        .div0  (div0)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] ref_q(input int a, input int b);
        return (b == 0) ? W'((1 << W) - 1) : W'(a / b);
    endfunction

    function automatic logic [W-1:0] ref_r(input int a, input int b);
        return (b == 0) ? W'(a) : W'(a % b);
    endfunction

    // Accepts one request and returns how many edges after the accept edge valid rose (-1 on timeout).
    task automatic do_div(input int a, input int b, output int k);
        x = W'(a);
        y = W'(b);
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (valid !== 1'b1 && k < 50) begin
            step();
            k++;
        end
        if (valid !== 1'b1) k = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; x = '0; y = '0;
        step(); step();
        rst = 1'b0;
        step();
        total++;
        if ({q, r, valid, busy, rdy} !== {4'd0, 4'd0, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset: q=%0d r=%0d valid=%b busy=%b rdy=%b, want 0 0 0 0 1", q, r, valid, busy, rdy);
        else passed++;
`ifdef DIVU_DIV0_EN
        total++;
        if (div0 !== 1'b0) $display("FAIL reset_div0: div0=%b want 0", div0);
        else passed++;
`endif
        $display("reset: q=%0d r=%0d valid=%b busy=%b rdy=%b", q, r, valid, busy, rdy);
    endtask

    task automatic test_basic();
        int bad = 0;
        x = 4'd13; y = 4'd3; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (busy !== 1'b1 || rdy !== 1'b0 || valid !== 1'b0) bad++;
            if (i < W - 1) step();
        end
        total++;
        if (bad != 0) $display("FAIL basic_busy: %0d busy cycles wrong, want 0", bad);
        else passed++;
        step();
        total++;
        if ({valid, busy, rdy, q, r} !== {1'b1, 1'b0, 1'b1, 4'd4, 4'd1})
            $display("FAIL basic_result: valid=%b busy=%b rdy=%b q=%0d r=%0d, want 1 0 1 4 1", valid, busy, rdy, q, r);
        else passed++;
        $display("basic 13/3: q=%0d r=%0d", q, r);
        step();
        total++;
        if ({valid, q, r} !== {1'b1, 4'd4, 4'd1})
            $display("FAIL basic_hold: valid=%b q=%0d r=%0d, want 1 4 1", valid, q, r);
        else passed++;
    endtask

    task automatic test_directed();
        int tx[3] = '{15, 2, 0};
        int ty[3] = '{1, 7, 5};
        int k;
        for (int i = 0; i < 3; i++) begin
            do_div(tx[i], ty[i], k);
            total++;
            if (k != W || q !== ref_q(tx[i], ty[i]) || r !== ref_r(tx[i], ty[i]))
                $display("FAIL directed %0d/%0d: lat=%0d q=%0d r=%0d, want lat=%0d q=%0d r=%0d",
                         tx[i], ty[i], k, q, r, W, ref_q(tx[i], ty[i]), ref_r(tx[i], ty[i]));
            else passed++;
            $display("directed %0d/%0d: q=%0d r=%0d lat=%0d", tx[i], ty[i], q, r, k);
        end
    endtask

    task automatic test_sweep();
        int k;
        int a;
        int b;
        int bad = 0;
        for (int i = 0; i < 16; i++) begin
            for (int j = 1; j < 16; j++) begin
                do_div(i, j, k);
                total++;
                if (k != W || int'(q) * j + int'(r) != i || int'(r) >= j || q !== ref_q(i, j)) begin
                    $display("FAIL sweep %0d/%0d: lat=%0d q=%0d r=%0d, want lat=%0d q=%0d r=%0d",
                             i, j, k, q, r, W, ref_q(i, j), ref_r(i, j));
                    bad++;
                end else passed++;
            end
        end
        $display("sweep: 240 pairs, %0d wrong", bad);
        for (int n = 0; n < 40; n++) begin
            a = int'($urandom_range(15, 0));
            b = int'($urandom_range(15, 0));
            do_div(a, b, k);
            total++;
            if (k < 0 || q !== ref_q(a, b) || r !== ref_r(a, b))
                $display("FAIL random %0d/%0d: lat=%0d q=%0d r=%0d, want q=%0d r=%0d",
                         a, b, k, q, r, ref_q(a, b), ref_r(a, b));
            else passed++;
            $display("random %0d/%0d: q=%0d r=%0d lat=%0d", a, b, q, r, k);
        end
    endtask

    task automatic test_div0();
        int k;
        int want_k;
`ifdef DIVU_DIV0_EN
        want_k = 0;
`else
        want_k = W;
`endif
        do_div(9, 0, k);
        total++;
        if (k != want_k || q !== 4'd15 || r !== 4'd9)
            $display("FAIL div0 9/0: lat=%0d q=%0d r=%0d, want lat=%0d q=15 r=9", k, q, r, want_k);
        else passed++;
        $display("div0 9/0: q=%0d r=%0d lat=%0d", q, r, k);
`ifdef DIVU_DIV0_EN
        total++;
        if (div0 !== 1'b1) $display("FAIL div0_flag: div0=%b want 1", div0);
        else passed++;
        do_div(9, 2, k);
        total++;
        if (div0 !== 1'b0 || q !== 4'd4 || r !== 4'd1 || k != W)
            $display("FAIL div0_clear: div0=%b q=%0d r=%0d lat=%0d, want 0 4 1 %0d", div0, q, r, k, W);
        else passed++;
`endif
    endtask

    task automatic test_start_ignored();
        int k;
        x = 4'd13; y = 4'd3; start = 1'b1;
        step();
        start = 1'b0;
        step();
        x = 4'd15; y = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        k = 2;
        while (valid !== 1'b1 && k < 50) begin
            step();
            k++;
        end
        total++;
        if (k != W || q !== 4'd4 || r !== 4'd1)
            $display("FAIL start_ignored: lat=%0d q=%0d r=%0d, want lat=%0d q=4 r=1", k, q, r, W);
        else passed++;
        $display("start_ignored: q=%0d r=%0d lat=%0d", q, r, k);
    endtask

    task automatic test_reset_mid();
        int k;
        x = 4'd13; y = 4'd3; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if ({q, r, valid, busy, rdy} !== {4'd0, 4'd0, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset_mid: q=%0d r=%0d valid=%b busy=%b rdy=%b, want 0 0 0 0 1", q, r, valid, busy, rdy);
        else passed++;
        step();
        total++;
        if ({valid, busy} !== 2'b00)
            $display("FAIL reset_mid_idle: valid=%b busy=%b, want 0 0", valid, busy);
        else passed++;
        do_div(10, 4, k);
        total++;
        if (k != W || q !== 4'd2 || r !== 4'd2)
            $display("FAIL reset_mid_next: lat=%0d q=%0d r=%0d, want lat=%0d q=2 r=2", k, q, r, W);
        else passed++;
        $display("reset_mid then 10/4: q=%0d r=%0d lat=%0d", q, r, k);
    endtask

    task automatic test_back_to_back();
        int last = -1;
        int hits = 0;
        int bad = 0;
        x = 4'd7; y = 4'd2; start = 1'b1;
        for (int i = 0; i < 25; i++) begin
            step();
            if (valid === 1'b1) begin
                hits++;
                if (q !== 4'd3 || r !== 4'd1) bad++;
                if (last >= 0 && i - last != W + 1) bad++;
                last = i;
            end
        end
        start = 1'b0;
        total++;
        if (hits != 5 || bad != 0)
            $display("FAIL back_to_back: results=%0d errors=%0d, want 5 0", hits, bad);
        else passed++;
        $display("back_to_back 7/2: %0d results, %0d errors", hits, bad);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; x = '0; y = '0;
        test_reset();
        test_basic();
        test_directed();
        test_sweep();
        test_div0();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
